// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, types and ALU select codes for the issue stage and ALU32bit
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int SEL_W   = 4;

  typedef logic [XLEN-1:0]    xword_t;
  typedef logic [RADDR_W-1:0] raddr_t;
  typedef logic [SEL_W-1:0]   alu_sel_t;

  localparam alu_sel_t ALU_ADD = 4'b0000;
  localparam alu_sel_t ALU_SUB = 4'b0001;
  localparam alu_sel_t ALU_AND = 4'b0010;
  localparam alu_sel_t ALU_OR  = 4'b0011;
  localparam alu_sel_t ALU_XOR = 4'b0100;
endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode, bypass and ALU-side signal bundle for alu_issue_stage
interface alu_issue_if;
  import alu_pkg::*;

  logic     dec_valid;
  logic     dec_ready;
  raddr_t   dec_rs1_addr;
  raddr_t   dec_rs2_addr;
  xword_t   dec_rs1_data;
  xword_t   dec_rs2_data;
  xword_t   dec_imm;
  logic     dec_use_imm;
  alu_sel_t dec_alu_sel;
  raddr_t   dec_rd_addr;
  logic     dec_rd_we;

  raddr_t   exm_rd_addr;
  logic     exm_rd_we;
  logic     exm_is_load;
  xword_t   exm_result;
  raddr_t   wb_rd_addr;
  logic     wb_we;
  xword_t   wb_data;
  logic     flush;

  xword_t   OperandA;
  xword_t   OperandB;
  alu_sel_t ALUsel;
  logic     ex_valid;
  logic     ex_ready;
  raddr_t   ex_rd_addr;
  logic     ex_rd_we;

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_data, dec_rs2_data,
           dec_imm, dec_use_imm, dec_alu_sel, dec_rd_addr, dec_rd_we,
           exm_rd_addr, exm_rd_we, exm_is_load, exm_result,
           wb_rd_addr, wb_we, wb_data, flush, ex_ready,
    output dec_ready, OperandA, OperandB, ALUsel, ex_valid, ex_rd_addr, ex_rd_we
  );

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_data, dec_rs2_data,
           dec_imm, dec_use_imm, dec_alu_sel, dec_rd_addr, dec_rd_we,
           exm_rd_addr, exm_rd_we, exm_is_load, exm_result,
           wb_rd_addr, wb_we, wb_data, flush, ex_ready,
    input  dec_ready, OperandA, OperandB, ALUsel, ex_valid, ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/alu_fwd_mux.sv
// rtl/alu_fwd_mux.sv - single-source bypass select: EX/MEM over MEM/WB over register file
module alu_fwd_mux
  import alu_pkg::*;
(
  input  raddr_t rs_addr,
  input  xword_t rf_data,
  input  raddr_t exm_rd_addr,
  input  logic   exm_rd_we,
  input  logic   exm_is_load,
  input  xword_t exm_result,
  input  raddr_t wb_rd_addr,
  input  logic   wb_we,
  input  xword_t wb_data,
  output xword_t data
);
  logic rs_nz;
  logic hit_exm;
  logic hit_wb;

  // x0 never bypasses; a load in EX/MEM has no data yet and is handled by the stall
  assign rs_nz   = (rs_addr != '0);
  assign hit_exm = exm_rd_we && !exm_is_load && (exm_rd_addr == rs_addr) && rs_nz;
  assign hit_wb  = wb_we && (wb_rd_addr == rs_addr) && rs_nz;

  always_comb begin
    data = rf_data;
    if (hit_exm)     data = exm_result;
    else if (hit_wb) data = wb_data;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX register feeding ALU32bit with bypass, load-use stall and flush
// Forwarding and load-use stall are built only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage
  import alu_pkg::*;
(
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  xword_t rs1_val;
  xword_t rs2_val;
  xword_t opb_next;
  logic   stall;
  logic   can_take;
  logic   accept;

`ifdef ALU_ISSUE_FWD_EN
  logic exm_load_live;

  alu_fwd_mux u_fwd_rs1 (
    .rs_addr     (bus.dec_rs1_addr),
    .rf_data     (bus.dec_rs1_data),
    .exm_rd_addr (bus.exm_rd_addr),
    .exm_rd_we   (bus.exm_rd_we),
    .exm_is_load (bus.exm_is_load),
    .exm_result  (bus.exm_result),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_we       (bus.wb_we),
    .wb_data     (bus.wb_data),
    .data        (rs1_val)
  );

  alu_fwd_mux u_fwd_rs2 (
    .rs_addr     (bus.dec_rs2_addr),
    .rf_data     (bus.dec_rs2_data),
    .exm_rd_addr (bus.exm_rd_addr),
    .exm_rd_we   (bus.exm_rd_we),
    .exm_is_load (bus.exm_is_load),
    .exm_result  (bus.exm_result),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_we       (bus.wb_we),
    .wb_data     (bus.wb_data),
    .data        (rs2_val)
  );

  // rs2 only matters when OperandB actually reads it
  assign exm_load_live = bus.exm_is_load && bus.exm_rd_we && (bus.exm_rd_addr != '0);
  assign stall = exm_load_live &&
                 ((bus.exm_rd_addr == bus.dec_rs1_addr) ||
                  (!bus.dec_use_imm && (bus.exm_rd_addr == bus.dec_rs2_addr)));
`else
  assign rs1_val = bus.dec_rs1_data;
  assign rs2_val = bus.dec_rs2_data;
  assign stall   = 1'b0;
`endif

  assign opb_next      = bus.dec_use_imm ? bus.dec_imm : rs2_val;
  assign can_take      = !bus.ex_valid || bus.ex_ready;
  assign bus.dec_ready = !stall && can_take && !bus.flush;
  assign accept        = bus.dec_valid && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid   <= 1'b0;
      bus.OperandA   <= '0;
      bus.OperandB   <= '0;
      bus.ALUsel     <= '0;
      bus.ex_rd_addr <= '0;
      bus.ex_rd_we   <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
      bus.ex_rd_we <= 1'b0;
    end else if (accept) begin
      bus.ex_valid   <= 1'b1;
      bus.OperandA   <= rs1_val;
      bus.OperandB   <= opb_next;
      bus.ALUsel     <= bus.dec_alu_sel;
      bus.ex_rd_addr <= bus.dec_rd_addr;
      bus.ex_rd_we   <= bus.dec_rd_we;
    end else if (bus.ex_valid && bus.ex_ready) begin
      bus.ex_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector table plus handshake, flush and reset sequences
module tb_alu_issue_stage;
  import alu_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    raddr_t   rs1;
    raddr_t   rs2;
    xword_t   d1;
    xword_t   d2;
    xword_t   imm;
    logic     use_imm;
    alu_sel_t sel;
    raddr_t   rd;
    raddr_t   exm_rd;
    logic     exm_we;
    logic     exm_ld;
    xword_t   exm_res;
    raddr_t   wb_rd;
    logic     wb_we;
    xword_t   wb_d;
    xword_t   a_f;
    xword_t   a_n;
    xword_t   b_f;
    xword_t   b_n;
    logic     rdy_f;
  } vec_t;

  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dec_valid    = 1'b0;
    bus.dec_rs1_addr = '0;
    bus.dec_rs2_addr = '0;
    bus.dec_rs1_data = '0;
    bus.dec_rs2_data = '0;
    bus.dec_imm      = '0;
    bus.dec_use_imm  = 1'b0;
    bus.dec_alu_sel  = '0;
    bus.dec_rd_addr  = '0;
    bus.dec_rd_we    = 1'b0;
    bus.exm_rd_addr  = '0;
    bus.exm_rd_we    = 1'b0;
    bus.exm_is_load  = 1'b0;
    bus.exm_result   = '0;
    bus.wb_rd_addr   = '0;
    bus.wb_we        = 1'b0;
    bus.wb_data      = '0;
    bus.flush        = 1'b0;
    bus.ex_ready     = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_simple(input xword_t a, input raddr_t rd);
    bus.dec_valid    = 1'b1;
    bus.dec_rs1_addr = 5'd1;
    bus.dec_rs1_data = a;
    bus.dec_rd_addr  = rd;
    bus.dec_rd_we    = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          rs1 rs2 d1     d2     imm     ui sel rd exr we ld res    wbr we wbd    a_f    a_n    b_f    b_n    rdy
    vecs[0] = '{1,  2,  32'h8, 32'h1, 32'h0,  0, 1,  4, 0,  0, 0, 32'h0, 0,  0, 32'h0, 32'h8, 32'h8, 32'h1, 32'h1, 1};
    vecs[1] = '{5,  6,  32'h7, 32'h9, 32'h0,  0, 2,  5, 5,  1, 0, 32'h20,5,  1, 32'h30,32'h20,32'h7, 32'h9, 32'h9, 1};
    vecs[2] = '{5,  6,  32'h7, 32'h9, 32'h0,  0, 2,  5, 5,  0, 0, 32'h20,5,  1, 32'h30,32'h30,32'h7, 32'h9, 32'h9, 1};
    vecs[3] = '{0,  0,  32'h11,32'h22,32'h0,  0, 3,  1, 0,  1, 0, 32'h20,0,  1, 32'h30,32'h11,32'h11,32'h22,32'h22,1};
    vecs[4] = '{1,  7,  32'h4, 32'h3, 32'h0,  0, 4,  2, 0,  0, 0, 32'h0, 7,  1, 32'h55,32'h4, 32'h4, 32'h55,32'h3, 1};
    vecs[5] = '{1,  7,  32'h4, 32'h3, 32'h100,1, 5,  2, 7,  1, 0, 32'hab,7,  1, 32'h55,32'h4, 32'h4, 32'h100,32'h100,1};
    vecs[6] = '{1,  3,  32'h6, 32'h3, 32'h8,  1, 1,  9, 3,  1, 1, 32'h77,0,  0, 32'h0, 32'h6, 32'h6, 32'h8, 32'h8, 1};
    vecs[7] = '{8,  9,  32'h1, 32'h2, 32'h0,  0, 2,  3, 9,  1, 0, 32'hab,9,  1, 32'hcd,32'h1, 32'h1, 32'hab,32'h2, 1};
    vecs[8] = '{2,  4,  32'h5, 32'h6, 32'h0,  0, 3,  7, 2,  1, 1, 32'h99,0,  0, 32'h0, 32'h5, 32'h5, 32'h6, 32'h6, 0};
    vecs[9] = '{2,  4,  32'h5, 32'h6, 32'h0,  0, 3,  7, 2,  0, 1, 32'h99,0,  0, 32'h0, 32'h5, 32'h5, 32'h6, 32'h6, 1};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("reset_opa", bus.OperandA, 32'd0);
    chk("reset_opb", bus.OperandB, 32'd0);
    chk("reset_sel", {28'b0, bus.ALUsel}, 32'd0);
    chk("reset_rd_we", {31'b0, bus.ex_rd_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_dec_ready", {31'b0, bus.dec_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      logic   rdy;
      xword_t ea;
      xword_t eb;
      rdy = FWD ? vecs[i].rdy_f : 1'b1;
      ea  = FWD ? vecs[i].a_f : vecs[i].a_n;
      eb  = FWD ? vecs[i].b_f : vecs[i].b_n;
      bus.dec_valid    = 1'b1;
      bus.dec_rs1_addr = vecs[i].rs1;
      bus.dec_rs2_addr = vecs[i].rs2;
      bus.dec_rs1_data = vecs[i].d1;
      bus.dec_rs2_data = vecs[i].d2;
      bus.dec_imm      = vecs[i].imm;
      bus.dec_use_imm  = vecs[i].use_imm;
      bus.dec_alu_sel  = vecs[i].sel;
      bus.dec_rd_addr  = vecs[i].rd;
      bus.dec_rd_we    = 1'b1;
      bus.exm_rd_addr  = vecs[i].exm_rd;
      bus.exm_rd_we    = vecs[i].exm_we;
      bus.exm_is_load  = vecs[i].exm_ld;
      bus.exm_result   = vecs[i].exm_res;
      bus.wb_rd_addr   = vecs[i].wb_rd;
      bus.wb_we        = vecs[i].wb_we;
      bus.wb_data      = vecs[i].wb_d;
      bus.ex_ready     = 1'b1;
      #1;
      chk($sformatf("v%0d_dec_ready", i), {31'b0, bus.dec_ready}, {31'b0, rdy});
      tick();
      if (rdy) begin
        chk($sformatf("v%0d_opa", i), bus.OperandA, ea);
        chk($sformatf("v%0d_opb", i), bus.OperandB, eb);
        chk($sformatf("v%0d_sel", i), {28'b0, bus.ALUsel}, {28'b0, vecs[i].sel});
        chk($sformatf("v%0d_rd", i), {27'b0, bus.ex_rd_addr}, {27'b0, vecs[i].rd});
        chk($sformatf("v%0d_valid", i), {31'b0, bus.ex_valid}, 32'd1);
      end else begin
        chk($sformatf("v%0d_drained", i), {31'b0, bus.ex_valid}, 32'd0);
      end
    end

    // load-use: stall while load sits in EX/MEM, then pick the value up from WB
    idle_inputs();
    bus.dec_valid    = 1'b1;
    bus.dec_rs2_addr = 5'd3;
    bus.dec_rs2_data = 32'h1;
    bus.dec_rd_addr  = 5'd6;
    bus.exm_rd_addr  = 5'd3;
    bus.exm_rd_we    = 1'b1;
    bus.exm_is_load  = 1'b1;
    #1;
    chk("lu_stall_ready", {31'b0, bus.dec_ready}, {31'b0, !FWD});
    tick();
    bus.exm_is_load = 1'b0;
    bus.exm_rd_we   = 1'b0;
    bus.wb_rd_addr  = 5'd3;
    bus.wb_we       = 1'b1;
    bus.wb_data     = 32'h44;
    #1;
    chk("lu_release_ready", {31'b0, bus.dec_ready}, 32'd1);
    tick();
    chk("lu_opb", bus.OperandB, FWD ? 32'h44 : 32'h1);
    chk("lu_valid", {31'b0, bus.ex_valid}, 32'd1);

    // backpressure: held output must not move, then no-bubble handoff
    idle_inputs();
    issue_simple(32'ha1, 5'd10);
    tick();
    chk("bp_first_opa", bus.OperandA, 32'ha1);
    bus.ex_ready = 1'b0;
    issue_simple(32'hb2, 5'd11);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready_c%0d", c), {31'b0, bus.dec_ready}, 32'd0);
      tick();
      chk($sformatf("bp_hold_opa_c%0d", c), bus.OperandA, 32'ha1);
      chk($sformatf("bp_hold_rd_c%0d", c), {27'b0, bus.ex_rd_addr}, 32'd10);
      chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, bus.ex_valid}, 32'd1);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, bus.dec_ready}, 32'd1);
    tick();
    chk("bp_next_opa", bus.OperandA, 32'hb2);
    chk("bp_next_valid", {31'b0, bus.ex_valid}, 32'd1);

    // flush with a live held instruction and a new one on decode
    bus.ex_ready = 1'b0;
    issue_simple(32'hc3, 5'd12);
    bus.flush = 1'b1;
    #1;
    chk("fl_dec_ready", {31'b0, bus.dec_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("fl_rd_we", {31'b0, bus.ex_rd_we}, 32'd0);
    bus.flush     = 1'b0;
    bus.dec_valid = 1'b0;
    bus.ex_ready  = 1'b1;
    tick();
    chk("fl_still_empty", {31'b0, bus.ex_valid}, 32'd0);
    chk("fl_not_captured", {31'b0, bus.OperandA != 32'hc3}, 32'd1);

    // reset while an instruction is held under backpressure
    issue_simple(32'hd4, 5'd13);
    bus.dec_alu_sel = ALU_SUB;
    tick();
    bus.ex_ready = 1'b0;
    tick();
    chk("rm_held", {31'b0, bus.ex_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rm_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rm_opa", bus.OperandA, 32'd0);
    chk("rm_opb", bus.OperandB, 32'd0);
    chk("rm_sel", {28'b0, bus.ALUsel}, 32'd0);
    chk("rm_rd", {27'b0, bus.ex_rd_addr}, 32'd0);
    rst = 1'b0;
    bus.dec_valid = 1'b0;
    #1;
    chk("rm_dec_ready", {31'b0, bus.dec_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of ALU32bit: registers decoded operands and drives ALU32bit's OperandA, OperandB and ALUsel.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, stalls on load-use, and flushes on a branch redirect.
- Valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width (matches ALU32bit).
- RADDR_W, 5, register-address width; register 0 is hard-wired zero.
- SEL_W, 4, ALU select width (matches ALUsel).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- dec_valid  input  1  decode presents an instruction.
- dec_ready  output  1  stage accepts this cycle.
- dec_rs1_addr, dec_rs2_addr  input  RADDR_W  source registers.
- dec_rs1_data, dec_rs2_data  input  XLEN  register-file read data.
- dec_imm  input  XLEN  sign-extended immediate.
- dec_use_imm  input  1  OperandB takes imm, not rs2.
- dec_alu_sel  input  SEL_W  ALU operation code.
- dec_rd_addr  input  RADDR_W  destination register.
- dec_rd_we  input  1  destination write enable.
- exm_rd_addr  input  RADDR_W  EX/MEM destination.
- exm_rd_we  input  1  EX/MEM writes.
- exm_is_load  input  1  EX/MEM holds a load (data not ready).
- exm_result  input  XLEN  EX/MEM ALU result.
- wb_rd_addr  input  RADDR_W  MEM/WB destination.
- wb_we  input  1  MEM/WB writes.
- wb_data  input  XLEN  MEM/WB write data.
- flush  input  1  kill held and incoming instruction.
- OperandA  output  XLEN  registered to ALU32bit.
- OperandB  output  XLEN  registered to ALU32bit.
- ALUsel  output  SEL_W  registered to ALU32bit.
- ex_valid  output  1  outputs hold a live instruction.
- ex_ready  input  1  downstream consumes.
- ex_rd_addr  output  RADDR_W  carried destination.
- ex_rd_we  output  1  carried write enable.

Behaviour:
- Reset (rst=1 at posedge): ex_valid=0, OperandA=0, OperandB=0, ALUsel=0, ex_rd_addr=0, ex_rd_we=0. rst overrides flush and the handshake; an in-flight instruction is dropped.
- Capture condition: accept = dec_valid & dec_ready. On accept, all outputs load at the next edge (latency 1) and ex_valid=1.
- Downstream handshake: if ex_valid & ex_ready & !accept, ex_valid clears next cycle. While ex_valid & !ex_ready, all outputs hold stable.
- dec_ready = !stall & (!ex_valid | ex_ready) & !flush.
- Load-use stall = exm_is_load & exm_rd_we & exm_rd_addr!=0 & (exm_rd_addr==dec_rs1_addr | (!dec_use_imm & exm_rd_addr==dec_rs2_addr)). Stall is evaluated combinationally each cycle and clears when the load leaves EX/MEM.
- Forwarding per source, evaluated in the capture cycle. For rs1 (OperandA):
  - if exm_rd_we & !exm_is_load & exm_rd_addr==rs1 & rs1!=0, take exm_result;
  - else if wb_we & wb_rd_addr==rs1 & rs1!=0, take wb_data;
  - else take dec_rs1_data.
  - EX/MEM has priority over WB.
- rs2 uses the same rule; the result is then muxed with dec_imm by dec_use_imm to form OperandB.
- rs=0 always yields register-file data (expected 0); x0 is never forwarded.
- flush: next cycle ex_valid=0 and ex_rd_we=0; no capture that cycle. Operand registers may hold stale values.
- Simultaneous flush & dec_valid: the instruction is dropped. Simultaneous ex_ready and accept: pass-through with no bubble.
- ALUsel is passed through unmodified; values are not checked.

Optional Feature:
- ALU_ISSUE_FWD_EN
- Defined: forwarding and load-use stall as above.
- Undefined: no forwarding muxes; OperandA=dec_rs1_data, OperandB=use_imm?imm:dec_rs2_data; stall is tied to 0. Software or upstream must insert NOPs.
- Ports are identical in both builds.

Decomposition:
- Package alu_pkg holds XLEN, RADDR_W, SEL_W, and the ALU select localparams shared with ALU32bit (e.g. ALU_ADD, ALU_SUB, and 4'b0001).
- One sub-module: alu_fwd_mux (single-source forwarding priority select), instantiated twice.
- Hazard detection stays inline.

Test Plan:
- Reset mid-operation: hold ex_valid=1, assert rst one cycle -> ex_valid=0, OperandA=OperandB=0, ALUsel=0, dec_ready=1 next cycle.
- Basic issue: rs1_data=8, rs2_data=1, use_imm=0, sel=4'b0001, no hazards -> next cycle OperandA=8, OperandB=1, ALUsel=0001, ex_valid=1.
- Double forward: rs1=5, exm_rd=5 with result 0x20, wb_rd=5 with data 0x30, rs1_data=0x7 -> OperandA=0x20. Repeat with exm_rd_we=0 -> 0x30. With rs1=0 and exm_rd=0 -> OperandA=rs1_data.
- Load-use: exm_is_load=1, exm_rd=3, dec_rs2=3, use_imm=0 -> dec_ready=0 and ex_valid deasserts after the drain. Drop exm_is_load and set wb_rd=3, wb_data=0x44 -> capture next cycle with OperandB=0x44. With use_imm=1 the same case does not stall.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with new dec_valid -> outputs stable and dec_ready=0. Then ex_ready=1 -> new instruction captured the same cycle with no bubble.
- Flush: flush=1 with dec_valid=1 and ex_valid=1 -> next cycle ex_valid=0 and ex_rd_we=0. The dropped instruction never appears.
